// File: rtl/uart_rx_framer_if.sv
// Byte handoff between the UART receiver and its consumer: valid/ready with the byte.
// The receiver drives the master side; the instruction/control unit drives the slave side.
interface uart_rx_framer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_framer.sv
// UART receiver: 8N1 framing with mid-bit sampling, start-bit glitch rejection,
// and framing/overrun error pulses.
module uart_rx_framer #(
  parameter int DATA_BITS = 8,
  parameter int MIN_CPB   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [12:0]       clks_per_bit,
  input  logic              rx_data_bit,
  uart_rx_framer_if.master  rx_if,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  localparam logic [12:0] MIN_CPB_L = 13'(MIN_CPB);
  localparam logic [3:0]  LAST_IDX  = 4'(DATA_BITS);

  // Programmed bit period, never shorter than the minimum the sampler supports.
  function automatic logic [12:0] clamp_cpb(input logic [12:0] n);
    clamp_cpb = (n < MIN_CPB_L) ? MIN_CPB_L : n;
  endfunction

  // Last count of the half-bit wait that lands the start sample mid-bit.
  function automatic logic [12:0] half_last(input logic [12:0] n);
    half_last = {1'b0, n[12:1]} - 13'd1;
  endfunction

  logic        sync_meta_q;
  logic        rx_s_q;

  state_t      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [12:0] nl_q, nl_d;
  logic [3:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        oerr_q, oerr_d;

  logic        bit_end;

  assign bit_end = (cnt_q == (nl_q - 13'd1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta_q <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      nl_q        <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      oerr_q      <= 1'b0;
    end else begin
      sync_meta_q <= rx_data_bit;
      rx_s_q      <= sync_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nl_q        <= nl_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      oerr_q      <= oerr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    nl_d      = nl_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    ferr_d    = 1'b0;
    oerr_d    = 1'b0;
    // A transfer empties the holding register unless STOP refills it below.
    valid_d   = (valid_q && rx_if.rx_ready) ? 1'b0 : valid_q;

    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d   = START;
          nl_d      = clamp_cpb(clks_per_bit);
          cnt_d     = '0;
          bit_idx_d = '0;
        end
      end

      START: begin
        if (cnt_q == half_last(nl_q)) begin
          cnt_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_idx_q < LAST_IDX) begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
          if (bit_idx_q == (LAST_IDX - 4'd1)) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end

      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end else if (valid_q && !rx_if.rx_ready) begin
            oerr_d  = 1'b1;
            state_d = IDLE;
          end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end

      // A stuck-low line after a bad stop bit must go high before a new start is accepted.
      WAIT_IDLE: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rx_if.rx_data  = data_q;
  assign rx_if.rx_valid = valid_q;
  assign busy           = (state_q != IDLE);
  assign frame_err      = ferr_q;
  assign overrun_err    = oerr_q;

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 Parameter: DATA_BITS, default 8, data bits per frame; only 8 is supported.
REQ-002 Parameter: MIN_CPB, default 4, minimum effective clks_per_bit; smaller programmed values are clamped to it.
REQ-003 Port: clk  input  1  system clock; all state is updated on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 Port: clks_per_bit  input  13  clock cycles per UART bit (N).
REQ-006 Port: rx_data_bit  input  1  asynchronous serial line; idles high.
REQ-007 Port: rx_data  output  8  received byte; held stable while rx_valid=1.
REQ-008 Port: rx_valid  output  1  byte available for the downstream instruction/control unit.
REQ-009 Port: rx_ready  input  1  consumer accepts the byte; a transfer occurs when rx_valid=1 and rx_ready=1 in the same cycle.
REQ-010 Port: busy  output  1  high in every state except IDLE.
REQ-011 Port: frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-012 Port: overrun_err  output  1  one-cycle pulse when a good frame completes while rx_valid=1 and rx_ready=0.

Function
REQ-013 rx_data_bit shall pass through a 2-flop synchronizer (rx_s); all decisions shall use rx_s only.
REQ-014 States: IDLE, START, DATA, STOP, WAIT_IDLE; the state register is 3 bits wide.
REQ-015 IDLE -> START when rx_s=0; in the same cycle, latch Nl = max(clks_per_bit, MIN_CPB) and clear the bit counter (13-bit).
REQ-016 A change on clks_per_bit during a frame shall not affect the frame in progress.
REQ-017 START: after floor(Nl/2) cycles, sample rx_s; if 0 -> DATA; if 1 -> IDLE (glitch rejected, no output activity).
REQ-018 DATA: sample rx_s every Nl cycles, 8 samples in total, LSB first, shifting into an internal shift register; after the 8th sample -> STOP.
REQ-019 STOP: sample rx_s Nl cycles after the 8th data sample.
  - Sample 1, no pending byte (rx_valid=0 or rx_ready=1 in that cycle): load rx_data, set rx_valid next cycle -> IDLE.
  - Sample 1, rx_valid=1 and rx_ready=0: drop the new byte, pulse overrun_err, keep the old byte -> IDLE.
  - Sample 0: pulse frame_err, no rx_valid -> WAIT_IDLE.
REQ-020 WAIT_IDLE -> IDLE on the first cycle with rx_s=1 (break/stuck-low line does not generate frames).
REQ-021 rx_valid clears the cycle after a transfer, unless a new byte is loaded in that same cycle, in which case it remains 1 with the new data.
REQ-022 IDLE re-arms in the cycle after STOP, so back-to-back frames with a single stop bit are received without loss.
REQ-023 Latency: rx_valid rises 1 cycle after the stop-bit sample, which is floor(Nl/2)+9*Nl cycles after rx_s first reads 0 (plus 2 synchronizer cycles from the pin).
REQ-024 Counters shall not wrap: the bit-time counter reloads to 0 at Nl-1; the bit index saturates at 8.

Reset
REQ-025 While reset=0: state=IDLE, rx_data=0x00, rx_valid=0, busy=0, frame_err=0, overrun_err=0, synchronizer flops=1, counters=0.
REQ-026 Reset asserted mid-frame shall abort the frame immediately with no output pulses; after release, the block waits in IDLE for rx_s=0.
REQ-027 Reset deassertion is synchronized externally; the block takes no action in the first cycle after release other than synchronizer shifting.

Verification
REQ-028 N=16, rx_ready=1, send 0xA5 with 1 stop bit -> rx_data=0xA5, rx_valid high for exactly 1 cycle, 8+144+1 cycles after rx_s falls; no error pulses.
REQ-029 N=16, a 5-cycle low glitch on an idle line -> return to IDLE, busy high for ~8 cycles, rx_valid stays 0.
REQ-030 N=16, send 0x3C with the stop bit held low, then the line high -> frame_err pulses once, rx_valid stays 0, and a following 0x81 is received correctly.
REQ-031 N=16, rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_data=0x11 with rx_valid held; overrun_err pulses at the 0x22 stop sample; after rx_ready=1 for 1 cycle, rx_valid=0.
REQ-032 clks_per_bit=1 (clamped to 4), send 0x5A -> rx_data=0x5A; changing clks_per_bit mid-frame to 100 -> the current frame is still decoded at N=4.
REQ-033 Assert reset during DATA bit 4 of 0xFF, release, then send 0x0F -> only 0x0F appears; no error pulses.
